digit_mux: RTL and testbench

Two-digit time-multiplexer for the dual seven-segment display. It captures hex key codes from the keypad path into a two-digit history: the newest key goes on the right and the previous key moves to the left. It alternates which digit is lit, inserting blanking gaps between digits to prevent ghosting. It drives the 4-bit nibble into the hex-to-seven-segment decoder and drives the active-low digit enables directly.

---
 rtl/digit_mux.sv | 120 ++++++++++++
 tb/tb_digit_mux.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/digit_mux.sv
// digit_mux
// Two-digit time multiplexer for a dual seven-segment display.
// Keeps a two-key history (newest on the right). Lights the right digit,
// then a blank gap, then the left digit, then another blank gap, and repeats.
// During each blank gap, s already carries the nibble for the next digit so
// the decoder output is settled before that digit is enabled.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   key_valid  one-cycle strobe; key carries a new hex code
//   key        hex key code
//   s          nibble to the hex-to-seven-segment decoder
//   an         active-low digit enables; an[0] = right (newest), an[1] = left
//   digits     stored history {left, right}
module digit_mux #(
    parameter int REFRESH_CYCLES = 24000,
    parameter int BLANK_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] s,
    output logic [1:0] an,
    output logic [7:0] digits
);

    localparam int MAX_RB = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int MAX_C  = (MAX_RB > 2) ? MAX_RB : 2;
    localparam int CW     = $clog2(MAX_C);

    localparam logic [CW-1:0] R_LAST    = CW'(REFRESH_CYCLES - 1);
    // B_LAST is never used when the blank phases are disabled; clamp to avoid
    // a negative constant.
    localparam logic [CW-1:0] B_LAST    = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic          HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        SHOW_R   = 2'd0,
        BLANK_RL = 2'd1,
        SHOW_L   = 2'd2,
        BLANK_LR = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    left;
    logic [3:0]    right;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHOW_R;
            cnt   <= '0;
            left  <= 4'h0;
            right <= 4'h0;
        end else begin
            // Key capture runs alongside the refresh FSM and never touches it.
            if (key_valid) begin
                left  <= right;
                right <= key;
            end

            case (state)
                SHOW_R: begin
                    if (cnt == R_LAST) begin
                        cnt   <= '0;
                        state <= HAS_BLANK ? BLANK_RL : SHOW_L;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK_RL: begin
                    if (cnt == B_LAST) begin
                        cnt   <= '0;
                        state <= SHOW_L;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW_L: begin
                    if (cnt == R_LAST) begin
                        cnt   <= '0;
                        state <= HAS_BLANK ? BLANK_LR : SHOW_R;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK_LR: begin
                    if (cnt == B_LAST) begin
                        cnt   <= '0;
                        state <= SHOW_R;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SHOW_R;
                end
            endcase
        end
    end

    // Output decode from registered state only; at most one enable is ever low.
    always_comb begin
        an = 2'b11;
        s  = right;
        case (state)
            SHOW_R:   begin an = 2'b10; s = right; end
            BLANK_RL: begin an = 2'b11; s = left;  end
            SHOW_L:   begin an = 2'b01; s = left;  end
            BLANK_LR: begin an = 2'b11; s = right; end
            default:  begin an = 2'b11; s = right; end
        endcase
    end

    assign digits = {left, right};

endmodule

// File: tb/tb_digit_mux.sv
// Bench for digit_mux: two instances (4/2 and 3/0 refresh/blank cycles)
// share stimulus and are compared every cycle against a model that derives
// the display phase from elapsed cycles modulo the refresh period and keeps
// the key history as two plain variables.
module tb_digit_mux;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key;

    logic [3:0] s_a, s_b;
    logic [1:0] an_a, an_b;
    logic [7:0] digits_a, digits_b;

    digit_mux #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
        .s(s_a), .an(an_a), .digits(digits_a)
    );

    digit_mux #(.REFRESH_CYCLES(3), .BLANK_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
        .s(s_b), .an(an_b), .digits(digits_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // model: cycles elapsed since the last reset edge, and key history
    int         t = 0;
    logic [3:0] m_left  = 4'h0;
    logic [3:0] m_right = 4'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    // 0 = right lit, 1 = blank before left, 2 = left lit, 3 = blank before right
    function automatic int phase_of(input int tt, input int r, input int b);
        int p;
        p = tt % (2 * (r + b));
        if (p < r)             return 0;
        else if (p < r + b)    return 1;
        else if (p < 2*r + b)  return 2;
        else                   return 3;
    endfunction

    function automatic logic [1:0] exp_an(input int ph);
        case (ph)
            0:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [3:0] exp_s(input int ph);
        return (ph == 0 || ph == 3) ? m_right : m_left;
    endfunction

    task automatic check_all();
        int pa, pb;
        pa = phase_of(t, 4, 2);
        pb = phase_of(t, 3, 0);
        chk("an_a",     32'(an_a),     32'(exp_an(pa)));
        chk("s_a",      32'(s_a),      32'(exp_s(pa)));
        chk("digits_a", 32'(digits_a), 32'({m_left, m_right}));
        chk("an_a_one_low", 32'(an_a != 2'b00), 32'd1);
        chk("an_b",     32'(an_b),     32'(exp_an(pb)));
        chk("s_b",      32'(s_b),      32'(exp_s(pb)));
        chk("digits_b", 32'(digits_b), 32'({m_left, m_right}));
    endtask

    // Called at a negedge: drive inputs, take one rising edge, update model,
    // then check at the following negedge.
    task automatic step(input logic r, input logic kv, input logic [3:0] k);
        reset     = r;
        key_valid = kv;
        key       = k;
        @(posedge clk);
        if (r) begin
            t       = 0;
            m_left  = 4'h0;
            m_right = 4'h0;
        end else begin
            t++;
            if (kv) begin
                m_left  = m_right;
                m_right = k;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b1;
        key       = 4'hF;
        @(negedge clk);

        // reset held 3 cycles with a key strobe present
        repeat (3) step(1'b1, 1'b1, 4'hF);

        // key-free refresh: two full periods of the 4/2 instance
        repeat (24) step(1'b0, 1'b0, 4'h0);

        // key shift 7 then A
        step(1'b0, 1'b1, 4'h7);
        repeat (5) step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hA);
        repeat (12) step(1'b0, 1'b0, 4'h0);

        // back-to-back 1,2,3; the 3 lands on the last SHOW_R cycle
        for (int i = 0; i < 12 && (t % 12) != 1; i++) step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 4'h3);
        repeat (14) step(1'b0, 1'b0, 4'h0);

        // load 5C, reset for one cycle during SHOW_L
        step(1'b0, 1'b1, 4'h5);
        step(1'b0, 1'b1, 4'hC);
        for (int i = 0; i < 12 && !((t % 12) >= 6 && (t % 12) <= 9); i++) step(1'b0, 1'b0, 4'h0);
        chk("pre_reset_digits", 32'(digits_a), 32'h5C);
        step(1'b1, 1'b0, 4'h0);
        repeat (8) step(1'b0, 1'b0, 4'h0);

        // randomized traffic with occasional resets
        repeat (600) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
